ex: RTL and testbench
=====================

Name: ex

Overview:
- Execute stage of the 5-stage MIPS pipeline.
- Consumes the registered ID/EX outputs and computes the result for logic, shift, arithmetic, move and link ops. Delivers wd/wreg/wdata and HI/LO writes to the EX/MEM register.
- Contains a 32-iteration sequential divider for DIV/DIVU.
- Holds the pipeline via stallreq_o while a division is in flight.

Parameters:
- DIV_ITER, 32, number of divider iterations; equals operand width `RegBus.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high (`RstEnable)
- aluop_i  in  `AluOpBus  operation from ID/EX
- alusel_i  in  `AluSelBus  result class from ID/EX
- reg1_i  in  `RegBus  operand 1
- reg2_i  in  `RegBus  operand 2
- wd_i  in  `RegAddrBus  destination register
- wreg_i  in  1  register write enable
- link_address_i  in  `RegBus  return address for jump/branch-and-link
- is_in_delayslot_i  in  1  instruction is in a delay slot
- hi_i, lo_i  in  `RegBus each  current HI/LO values
- ex_hold_i  in  1  stall[3]; downstream holds EX
- wd_o  out  `RegAddrBus  destination register
- wreg_o  out  1  register write enable
- wdata_o  out  `RegBus  result
- whilo_o  out  1  HI/LO write enable
- hi_o, lo_o  out  `RegBus each  HI/LO write data
- is_in_delayslot_o  out  1  pass-through of is_in_delayslot_i
- stallreq_o  out  1  stall request to ctrl

Behaviour:
- Result path: outputs are combinational from the inputs plus divider state.
- On reset: divider FSM returns to FREE and its internal dividend/quotient/count clear to 0.
  - Whenever rst is high, outputs are forced: wd_o=`NOPRegAddr, wreg_o=0, wdata_o=`ZeroWord, whilo_o=0, hi_o=lo_o=0, stallreq_o=0.
- Logic ops: AND, OR, XOR, NOR, LUI-style OR.
- Shifts: SLL/SRL/SRA; shift amount is reg1_i[4:0].
- Arithmetic:
  - ADD, ADDU, SUB, SUBU: 32-bit wrap.
  - SLT is signed; SLTU is unsigned.
  - ADD/SUB signed overflow forces wreg_o=0 (no trap yet). ADDU/SUBU never suppress.
- Move: MFHI→hi_i, MFLO→lo_i. MTHI/MTLO set whilo_o=1 and copy the operand into hi_o or lo_o; the other half keeps its current value.
- Jump/branch class: wdata_o=link_address_i.
- Divider FSM states: FREE, BYZERO, ON, END.
  - FREE + DIV/DIVU op: go to BYZERO if reg2_i==0, else to ON. Latch the operands; for DIV, latch absolute values and record the signs.
  - BYZERO → END; result is quotient=0, remainder=0.
  - ON: restoring shift-subtract, 1 bit/cycle, count 0..31. After the 32nd iteration go to END.
  - DIV sign fix at END: quotient is negated if the operand signs differ; remainder takes the dividend's sign.
    - Example: -7/2 → LO=-3, HI=-1.
  - END: whilo_o=1, lo_o=quotient, hi_o=remainder, stallreq_o=0. Stay in END while ex_hold_i=1; otherwise go to FREE next cycle.
  - stallreq_o=1 whenever a div op is present and the state is not END.
- Latency: op enters EX at cycle N. States are ON for N+1..N+32 and END at N+33. The result is visible and stallreq drops at N+33, so EX occupancy is 34 cycles. Divide-by-zero takes 3 cycles (END at N+2).
- Back-to-back DIVs: the second DIV enters while the FSM is FREE and starts normally.
- A non-div op while the FSM is not FREE cannot occur, because the stall holds ID/EX. Reset mid-division aborts it and the FSM returns to FREE.

Optional Feature:
- Macro EX_MULT_EN.
- Defined: MULT/MULTU are single-cycle combinational 32x32→64 ops, signed or unsigned; whilo_o=1, hi_o=prod[63:32], lo_o=prod[31:0]. MUL (GPR form) writes prod[31:0] to wdata_o.
- Undefined: these aluops produce wreg_o=0, whilo_o=0, wdata_o=0 (NOP).

Decomposition:
- cpu_pkg holds:
  - typedef div_state_t enum {DIV_FREE, DIV_BYZERO, DIV_ON, DIV_END}
  - typedef div_req_t struct {signed_op, dividend, divisor}
  - constant DIV_CNT_W=6
- aluop/alusel codes stay in defines.svh.
- One sub-module, div: the FSM plus datapath, with a start/ready handshake.
- ex stays the result mux plus hold logic.

Test Plan:
- ADD 0x7FFFFFFF+1 → wreg_o=0 (overflow); ADDU with the same operands → wdata_o=0x80000000, wreg_o=1.
- DIVU 100/7: stallreq_o high for cycles N..N+32, low at N+33; lo_o=14, hi_o=2, whilo_o=1.
- DIV -7/2 → lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF; DIV 7/-2 → lo_o=-3, hi_o=1.
- DIV x/0 → END at N+2, hi_o=lo_o=0. Then ex_hold_i=1 for 3 cycles: outputs stay stable, FSM stays in END.
- Reset asserted at ON iteration 10 → next cycle state FREE, stallreq_o=0; a new DIVU 9/3 afterwards yields 3 rem 0.
- With EX_MULT_EN: MULT 0xFFFFFFFF*2 → hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFE. Without it: the same op gives whilo_o=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Types shared by the execute stage and its sequential divider.
package cpu_pkg;
  localparam int unsigned DIV_CNT_W = 6;

  typedef enum logic [1:0] {DIV_FREE, DIV_BYZERO, DIV_ON, DIV_END} div_state_t;

  typedef struct packed {
    logic        signed_op;
    logic [31:0] dividend;
    logic [31:0] divisor;
  } div_req_t;
endpackage

// File: rtl/defines.svh
// Shared bus widths and ALU operation/result-class encodings for the MIPS pipeline.
`ifndef EX_DEFINES_SVH
`define EX_DEFINES_SVH

`define RstEnable    1'b1
`define ZeroWord     32'h00000000
`define AluOpBus     7:0
`define AluSelBus    2:0
`define RegBus       31:0
`define RegAddrBus   4:0
`define NOPRegAddr   5'b00000

`define EXE_AND_OP   8'b00100100
`define EXE_OR_OP    8'b00100101
`define EXE_XOR_OP   8'b00100110
`define EXE_NOR_OP   8'b00100111
`define EXE_LUI_OP   8'b01011100
`define EXE_SLL_OP   8'b01111100
`define EXE_SRL_OP   8'b00000010
`define EXE_SRA_OP   8'b00000011
`define EXE_MFHI_OP  8'b00010000
`define EXE_MTHI_OP  8'b00010001
`define EXE_MFLO_OP  8'b00010010
`define EXE_MTLO_OP  8'b00010011
`define EXE_SLT_OP   8'b00101010
`define EXE_SLTU_OP  8'b00101011
`define EXE_ADD_OP   8'b00100000
`define EXE_ADDU_OP  8'b00100001
`define EXE_SUB_OP   8'b00100010
`define EXE_SUBU_OP  8'b00100011
`define EXE_MULT_OP  8'b00011000
`define EXE_MULTU_OP 8'b00011001
`define EXE_MUL_OP   8'b10101001
`define EXE_DIV_OP   8'b00011010
`define EXE_DIVU_OP  8'b00011011

`define EXE_RES_NOP         3'b000
`define EXE_RES_LOGIC       3'b001
`define EXE_RES_SHIFT       3'b010
`define EXE_RES_MOVE        3'b011
`define EXE_RES_ARITHMETIC  3'b100
`define EXE_RES_MUL         3'b101
`define EXE_RES_JUMP_BRANCH 3'b110

`endif

// File: rtl/ex_div.sv
// Restoring shift-subtract divider, one quotient bit per cycle, start/ready handshake.
// Holds the result in END while hold is asserted.
module div
  import cpu_pkg::*;
#(
  parameter int unsigned DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        hold,
  input  div_req_t    req,
  output logic        ready,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  div_state_t state, state_next;
  logic [31:0] divisor_q, dividend_q, quotient_q;
  logic [DIV_CNT_W-1:0] cnt_q;
  logic neg_quo_q, neg_rem_q;
  logic [32:0] shifted, trial;
  logic last_iter;

  assign shifted   = {dividend_q, quotient_q[31]};
  assign trial     = shifted - {1'b0, divisor_q};
  assign last_iter = (cnt_q == DIV_CNT_W'(DIV_ITER - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= DIV_FREE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      DIV_FREE:   if (start) state_next = (req.divisor == '0) ? DIV_BYZERO : DIV_ON;
      DIV_BYZERO: state_next = DIV_END;
      DIV_ON:     if (last_iter) state_next = DIV_END;
      DIV_END:    if (!hold) state_next = DIV_FREE;
    endcase
  end

  // Operands are stored as magnitudes; signs are reapplied on the output side.
  always_ff @(posedge clk) begin
    if (rst) begin
      divisor_q  <= '0;
      dividend_q <= '0;
      quotient_q <= '0;
      cnt_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      case (state)
        DIV_FREE: if (start) begin
          divisor_q  <= (req.signed_op && req.divisor[31])  ? -req.divisor  : req.divisor;
          quotient_q <= (req.signed_op && req.dividend[31]) ? -req.dividend : req.dividend;
          dividend_q <= '0;
          cnt_q      <= '0;
          neg_quo_q  <= req.signed_op & (req.dividend[31] ^ req.divisor[31]);
          neg_rem_q  <= req.signed_op & req.dividend[31];
        end
        DIV_BYZERO: begin
          dividend_q <= '0;
          quotient_q <= '0;
        end
        DIV_ON: begin
          if (trial[32]) begin
            dividend_q <= shifted[31:0];
            quotient_q <= {quotient_q[30:0], 1'b0};
          end else begin
            dividend_q <= trial[31:0];
            quotient_q <= {quotient_q[30:0], 1'b1};
          end
          cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ready     = (state == DIV_END);
  assign quotient  = neg_quo_q ? -quotient_q : quotient_q;
  assign remainder = neg_rem_q ? -dividend_q : dividend_q;

endmodule

// File: rtl/ex.sv
// Execute stage: ALU result mux, HI/LO write generation and divider stall control.
// Optional EX_MULT_EN enables single-cycle MULT/MULTU/MUL.
`include "defines.svh"

module ex
  import cpu_pkg::*;
#(
  parameter int unsigned DIV_ITER = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [`AluOpBus]   aluop_i,
  input  logic [`AluSelBus]  alusel_i,
  input  logic [`RegBus]     reg1_i,
  input  logic [`RegBus]     reg2_i,
  input  logic [`RegAddrBus] wd_i,
  input  logic               wreg_i,
  input  logic [`RegBus]     link_address_i,
  input  logic               is_in_delayslot_i,
  input  logic [`RegBus]     hi_i,
  input  logic [`RegBus]     lo_i,
  input  logic               ex_hold_i,
  output logic [`RegAddrBus] wd_o,
  output logic               wreg_o,
  output logic [`RegBus]     wdata_o,
  output logic               whilo_o,
  output logic [`RegBus]     hi_o,
  output logic [`RegBus]     lo_o,
  output logic               is_in_delayslot_o,
  output logic               stallreq_o
);

  logic [`RegBus] logic_res, shift_res, move_res, arith_res, sum;
  logic           is_sub, ov_suppress, div_op, div_ready;
  logic [`RegBus] div_quo, div_rem;
  div_req_t       div_req;

  always_comb begin
    logic_res = '0;
    case (aluop_i)
      `EXE_AND_OP:             logic_res = reg1_i & reg2_i;
      `EXE_OR_OP, `EXE_LUI_OP: logic_res = reg1_i | reg2_i;
      `EXE_XOR_OP:             logic_res = reg1_i ^ reg2_i;
      `EXE_NOR_OP:             logic_res = ~(reg1_i | reg2_i);
      default:                 logic_res = '0;
    endcase
  end

  always_comb begin
    shift_res = '0;
    case (aluop_i)
      `EXE_SLL_OP: shift_res = reg2_i << reg1_i[4:0];
      `EXE_SRL_OP: shift_res = reg2_i >> reg1_i[4:0];
      `EXE_SRA_OP: shift_res = $signed(reg2_i) >>> reg1_i[4:0];
      default:     shift_res = '0;
    endcase
  end

  always_comb begin
    move_res = '0;
    case (aluop_i)
      `EXE_MFHI_OP: move_res = hi_i;
      `EXE_MFLO_OP: move_res = lo_i;
      default:      move_res = '0;
    endcase
  end

  assign is_sub = (aluop_i == `EXE_SUB_OP) || (aluop_i == `EXE_SUBU_OP);
  assign sum    = is_sub ? (reg1_i - reg2_i) : (reg1_i + reg2_i);

  // Signed overflow: add of like signs, or subtract of unlike signs, flipping the sign.
  assign ov_suppress =
      ((aluop_i == `EXE_ADD_OP) && (reg1_i[31] == reg2_i[31]) && (sum[31] != reg1_i[31])) ||
      ((aluop_i == `EXE_SUB_OP) && (reg1_i[31] != reg2_i[31]) && (sum[31] != reg1_i[31]));

  always_comb begin
    arith_res = '0;
    case (aluop_i)
      `EXE_ADD_OP, `EXE_ADDU_OP, `EXE_SUB_OP, `EXE_SUBU_OP: arith_res = sum;
      `EXE_SLT_OP:  arith_res = {31'b0, $signed(reg1_i) < $signed(reg2_i)};
      `EXE_SLTU_OP: arith_res = {31'b0, reg1_i < reg2_i};
      default:      arith_res = '0;
    endcase
  end

`ifdef EX_MULT_EN
  logic        mult_signed;
  logic [63:0] op1_ext, op2_ext, prod;
  assign mult_signed = (aluop_i != `EXE_MULTU_OP);
  assign op1_ext     = mult_signed ? {{32{reg1_i[31]}}, reg1_i} : {32'b0, reg1_i};
  assign op2_ext     = mult_signed ? {{32{reg2_i[31]}}, reg2_i} : {32'b0, reg2_i};
  assign prod        = op1_ext * op2_ext;
`endif

  assign div_op  = (aluop_i == `EXE_DIV_OP) || (aluop_i == `EXE_DIVU_OP);
  assign div_req = '{signed_op: (aluop_i == `EXE_DIV_OP), dividend: reg1_i, divisor: reg2_i};

  div #(.DIV_ITER(DIV_ITER)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_op),
    .hold      (ex_hold_i),
    .req       (div_req),
    .ready     (div_ready),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  assign is_in_delayslot_o = is_in_delayslot_i;

  always_comb begin
    wd_o       = wd_i;
    wreg_o     = wreg_i;
    wdata_o    = `ZeroWord;
    whilo_o    = 1'b0;
    hi_o       = `ZeroWord;
    lo_o       = `ZeroWord;
    stallreq_o = 1'b0;
    if (rst == `RstEnable) begin
      wd_o   = `NOPRegAddr;
      wreg_o = 1'b0;
    end else begin
      case (alusel_i)
        `EXE_RES_LOGIC:       wdata_o = logic_res;
        `EXE_RES_SHIFT:       wdata_o = shift_res;
        `EXE_RES_MOVE:        wdata_o = move_res;
        `EXE_RES_ARITHMETIC:  wdata_o = arith_res;
`ifdef EX_MULT_EN
        `EXE_RES_MUL:         wdata_o = prod[31:0];
`endif
        `EXE_RES_JUMP_BRANCH: wdata_o = link_address_i;
        default:              wdata_o = `ZeroWord;
      endcase
      if (ov_suppress) wreg_o = 1'b0;
      case (aluop_i)
        `EXE_MTHI_OP: begin
          whilo_o = 1'b1;
          hi_o    = reg1_i;
          lo_o    = lo_i;
        end
        `EXE_MTLO_OP: begin
          whilo_o = 1'b1;
          hi_o    = hi_i;
          lo_o    = reg1_i;
        end
`ifdef EX_MULT_EN
        `EXE_MULT_OP, `EXE_MULTU_OP: begin
          whilo_o = 1'b1;
          hi_o    = prod[63:32];
          lo_o    = prod[31:0];
        end
`else
        `EXE_MULT_OP, `EXE_MULTU_OP, `EXE_MUL_OP: wreg_o = 1'b0;
`endif
        `EXE_DIV_OP, `EXE_DIVU_OP: begin
          stallreq_o = !div_ready;
          whilo_o    = div_ready;
          if (div_ready) begin
            hi_o = div_rem;
            lo_o = div_quo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex.sv
// Self-checking bench for the execute stage: behavioural model compared every cycle
// plus directed vectors with literal expectations.
module tb_ex;
  localparam logic [7:0] OP_NOP = 8'h00, OP_AND = 8'b00100100, OP_OR = 8'b00100101,
    OP_XOR = 8'b00100110, OP_NOR = 8'b00100111, OP_LUI = 8'b01011100,
    OP_SLL = 8'b01111100, OP_SRL = 8'b00000010, OP_SRA = 8'b00000011,
    OP_MFHI = 8'b00010000, OP_MTHI = 8'b00010001, OP_MFLO = 8'b00010010,
    OP_MTLO = 8'b00010011, OP_SLT = 8'b00101010, OP_SLTU = 8'b00101011,
    OP_ADD = 8'b00100000, OP_ADDU = 8'b00100001, OP_SUB = 8'b00100010,
    OP_SUBU = 8'b00100011, OP_MULT = 8'b00011000, OP_MULTU = 8'b00011001,
    OP_MUL = 8'b10101001, OP_DIV = 8'b00011010, OP_DIVU = 8'b00011011;
  localparam logic [2:0] SEL_NOP = 3'd0, SEL_LOGIC = 3'd1, SEL_SHIFT = 3'd2, SEL_MOVE = 3'd3,
    SEL_ARITH = 3'd4, SEL_MUL = 3'd5, SEL_JUMP = 3'd6;

  logic clk = 1'b0;
  logic rst, wreg_i, dslot_i, ex_hold_i;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i, reg2_i, link_i, hi_i, lo_i;
  logic [4:0]  wd_i;
  logic [4:0]  wd_o;
  logic        wreg_o, whilo_o, dslot_o, stallreq_o;
  logic [31:0] wdata_o, hi_o, lo_o;

  int n_vec = 0;
  int n_fail = 0;
  int div_cycles = 0;

  always #5 clk = ~clk;

  ex #(.DIV_ITER(32)) dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .link_address_i(link_i), .is_in_delayslot_i(dslot_i), .hi_i(hi_i), .lo_i(lo_i),
    .ex_hold_i(ex_hold_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o), .is_in_delayslot_o(dslot_o),
    .stallreq_o(stallreq_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_div(input logic [7:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic int div_lat(input logic [31:0] divisor);
    return (divisor == 32'h0) ? 2 : 33;
  endfunction

  // Cycles the current divide has been resident in EX.
  always @(posedge clk) begin
    if (rst || !is_div(aluop_i)) div_cycles <= 0;
    else if (div_cycles >= div_lat(reg2_i) && !ex_hold_i) div_cycles <= 0;
    else div_cycles <= div_cycles + 1;
  end

  logic [31:0] e_wdata, e_hi, e_lo;
  logic [4:0]  e_wd;
  logic        e_wreg, e_whilo, e_stall;
  longint      sa, sb, full;
  longint unsigned uprod;
  bit          done;

  always @(negedge clk) begin : compare
    sa = longint'($signed(reg1_i));
    sb = longint'($signed(reg2_i));
    e_wd = wd_i; e_wreg = wreg_i; e_wdata = 32'h0;
    e_whilo = 1'b0; e_hi = 32'h0; e_lo = 32'h0; e_stall = 1'b0;
    if (rst) begin
      e_wd = 5'd0;
      e_wreg = 1'b0;
    end else begin
      case (alusel_i)
        SEL_LOGIC: case (aluop_i)
          OP_AND: e_wdata = reg1_i & reg2_i;
          OP_OR, OP_LUI: e_wdata = reg1_i | reg2_i;
          OP_XOR: e_wdata = reg1_i ^ reg2_i;
          OP_NOR: e_wdata = ~(reg1_i | reg2_i);
          default: e_wdata = 32'h0;
        endcase
        SEL_SHIFT: case (aluop_i)
          OP_SLL: e_wdata = 32'(longint'({32'h0, reg2_i}) << reg1_i[4:0]);
          OP_SRL: e_wdata = 32'(longint'({32'h0, reg2_i}) >> reg1_i[4:0]);
          OP_SRA: e_wdata = 32'(sb >>> reg1_i[4:0]);
          default: e_wdata = 32'h0;
        endcase
        SEL_MOVE: e_wdata = (aluop_i == OP_MFHI) ? hi_i : (aluop_i == OP_MFLO) ? lo_i : 32'h0;
        SEL_ARITH: case (aluop_i)
          OP_ADD, OP_ADDU: e_wdata = 32'(sa + sb);
          OP_SUB, OP_SUBU: e_wdata = 32'(sa - sb);
          OP_SLT: e_wdata = (sa < sb) ? 32'd1 : 32'd0;
          OP_SLTU: e_wdata = (reg1_i < reg2_i) ? 32'd1 : 32'd0;
          default: e_wdata = 32'h0;
        endcase
`ifdef EX_MULT_EN
        SEL_MUL: e_wdata = 32'(sa * sb);
`endif
        SEL_JUMP: e_wdata = link_i;
        default: e_wdata = 32'h0;
      endcase
      full = (aluop_i == OP_ADD) ? sa + sb : (aluop_i == OP_SUB) ? sa - sb : 64'sd0;
      if (full > 64'sd2147483647 || full < -64'sd2147483648) e_wreg = 1'b0;
      case (aluop_i)
        OP_MTHI: begin e_whilo = 1'b1; e_hi = reg1_i; e_lo = lo_i; end
        OP_MTLO: begin e_whilo = 1'b1; e_hi = hi_i; e_lo = reg1_i; end
`ifdef EX_MULT_EN
        OP_MULT: begin e_whilo = 1'b1; uprod = longint'(sa * sb); e_hi = uprod[63:32]; e_lo = uprod[31:0]; end
        OP_MULTU: begin
          e_whilo = 1'b1;
          uprod = longint'({32'h0, reg1_i}) * longint'({32'h0, reg2_i});
          e_hi = uprod[63:32]; e_lo = uprod[31:0];
        end
`else
        OP_MULT, OP_MULTU, OP_MUL: e_wreg = 1'b0;
`endif
        OP_DIV, OP_DIVU: begin
          done = div_cycles >= div_lat(reg2_i);
          e_stall = !done;
          e_whilo = done;
          if (done && reg2_i != 32'h0) begin
            if (aluop_i == OP_DIV) begin
              e_lo = 32'(sa / sb);
              e_hi = 32'(sa % sb);
            end else begin
              e_lo = reg1_i / reg2_i;
              e_hi = reg1_i % reg2_i;
            end
          end
        end
        default: ;
      endcase
    end
    chk("model_wd", 32'(wd_o), 32'(e_wd));
    chk("model_wreg", 32'(wreg_o), 32'(e_wreg));
    chk("model_wdata", wdata_o, e_wdata);
    chk("model_whilo", 32'(whilo_o), 32'(e_whilo));
    chk("model_hi", hi_o, e_hi);
    chk("model_lo", lo_o, e_lo);
    chk("model_stall", 32'(stallreq_o), 32'(e_stall));
    chk("model_dslot", 32'(dslot_o), 32'(dslot_i));
  end

  task automatic step(input logic [7:0] op, input logic [2:0] sel,
                      input logic [31:0] a, input logic [31:0] b, input logic wr);
    @(posedge clk); #1;
    aluop_i = op; alusel_i = sel; reg1_i = a; reg2_i = b; wreg_i = wr;
    wd_i = wd_i + 5'd1;
    @(negedge clk);
  endtask

  task automatic run_div(input string name, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] q, input logic [31:0] r);
    int lat;
    lat = (b == 32'h0) ? 2 : 33;
    @(posedge clk); #1;
    aluop_i = op; alusel_i = SEL_NOP; reg1_i = a; reg2_i = b; wreg_i = 1'b0;
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      chk({name, "_stall"}, 32'(stallreq_o), (k < lat) ? 32'd1 : 32'd0);
    end
    chk({name, "_whilo"}, 32'(whilo_o), 32'd1);
    chk({name, "_lo"}, lo_o, q);
    chk({name, "_hi"}, hi_o, r);
  endtask

  initial begin
    rst = 1'b1; aluop_i = OP_ADD; alusel_i = SEL_ARITH; reg1_i = 32'd1; reg2_i = 32'd2;
    wd_i = 5'd5; wreg_i = 1'b1; link_i = 32'h0; dslot_i = 1'b0;
    hi_i = 32'h00001234; lo_i = 32'h00005678; ex_hold_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_wd", 32'(wd_o), 32'd0);
    chk("rst_wreg", 32'(wreg_o), 32'd0);
    chk("rst_wdata", wdata_o, 32'h0);
    chk("rst_stall", 32'(stallreq_o), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    step(OP_ADD, SEL_ARITH, 32'h7FFFFFFF, 32'h1, 1'b1);
    chk("add_ov_wreg", 32'(wreg_o), 32'd0);
    step(OP_ADDU, SEL_ARITH, 32'h7FFFFFFF, 32'h1, 1'b1);
    chk("addu_wdata", wdata_o, 32'h80000000);
    chk("addu_wreg", 32'(wreg_o), 32'd1);
    step(OP_SUB, SEL_ARITH, 32'h80000000, 32'h1, 1'b1);
    chk("sub_ov_wreg", 32'(wreg_o), 32'd0);
    step(OP_SUBU, SEL_ARITH, 32'd5, 32'd7, 1'b1);
    chk("subu_wdata", wdata_o, 32'hFFFFFFFE);
    step(OP_AND, SEL_LOGIC, 32'hF0F000FF, 32'h0FF00F0F, 1'b1);
    chk("and", wdata_o, 32'h00F0000F);
    step(OP_OR, SEL_LOGIC, 32'hF0F000FF, 32'h0FF00F0F, 1'b1);
    chk("or", wdata_o, 32'hFFF00FFF);
    step(OP_XOR, SEL_LOGIC, 32'hF0F000FF, 32'h0FF00F0F, 1'b1);
    chk("xor", wdata_o, 32'hFF000FF0);
    step(OP_NOR, SEL_LOGIC, 32'hF0F000FF, 32'h0FF00F0F, 1'b1);
    chk("nor", wdata_o, 32'h000FF000);
    step(OP_LUI, SEL_LOGIC, 32'h0, 32'h12340000, 1'b1);
    chk("lui", wdata_o, 32'h12340000);
    step(OP_SLL, SEL_SHIFT, 32'd4, 32'h8000000F, 1'b1);
    chk("sll", wdata_o, 32'h000000F0);
    step(OP_SRL, SEL_SHIFT, 32'd4, 32'h8000000F, 1'b1);
    chk("srl", wdata_o, 32'h08000000);
    step(OP_SRA, SEL_SHIFT, 32'd4, 32'h8000000F, 1'b1);
    chk("sra", wdata_o, 32'hF8000000);
    step(OP_SLT, SEL_ARITH, 32'hFFFFFFFF, 32'd1, 1'b1);
    chk("slt", wdata_o, 32'd1);
    step(OP_SLTU, SEL_ARITH, 32'hFFFFFFFF, 32'd1, 1'b1);
    chk("sltu", wdata_o, 32'd0);
    step(OP_MFHI, SEL_MOVE, 32'h0, 32'h0, 1'b1);
    chk("mfhi", wdata_o, 32'h00001234);
    step(OP_MTLO, SEL_MOVE, 32'h000000AB, 32'h0, 1'b0);
    chk("mtlo_whilo", 32'(whilo_o), 32'd1);
    chk("mtlo_lo", lo_o, 32'h000000AB);
    chk("mtlo_hi", hi_o, 32'h00001234);
    dslot_i = 1'b1; link_i = 32'h00000400;
    step(OP_NOP, SEL_JUMP, 32'h0, 32'h0, 1'b1);
    chk("link", wdata_o, 32'h00000400);
    chk("dslot", 32'(dslot_o), 32'd1);
    dslot_i = 1'b0;

    step(OP_MULT, SEL_NOP, 32'hFFFFFFFF, 32'd2, 1'b0);
`ifdef EX_MULT_EN
    chk("mult_hi", hi_o, 32'hFFFFFFFF);
    chk("mult_lo", lo_o, 32'hFFFFFFFE);
    step(OP_MULTU, SEL_NOP, 32'hFFFFFFFF, 32'd2, 1'b0);
    chk("multu_hi", hi_o, 32'h00000001);
    step(OP_MUL, SEL_MUL, 32'd3, 32'hFFFFFFFB, 1'b1);
    chk("mul_wdata", wdata_o, 32'hFFFFFFF1);
`else
    chk("mult_off_whilo", 32'(whilo_o), 32'd0);
    step(OP_MUL, SEL_MUL, 32'd3, 32'hFFFFFFFB, 1'b1);
    chk("mul_off_wreg", 32'(wreg_o), 32'd0);
`endif

    run_div("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 32'd2);
    run_div("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
    run_div("div_7_m2", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1);
    run_div("div_by0", OP_DIV, 32'd5, 32'h0, 32'h0, 32'h0);
    ex_hold_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_whilo", 32'(whilo_o), 32'd1);
      chk("hold_stall", 32'(stallreq_o), 32'd0);
      chk("hold_lo", lo_o, 32'h0);
    end
    ex_hold_i = 1'b0;

    @(posedge clk); #1;
    aluop_i = OP_DIVU; alusel_i = SEL_NOP; reg1_i = 32'd1000; reg2_i = 32'd3; wreg_i = 1'b0;
    repeat (11) @(negedge clk);
    chk("mid_stall", 32'(stallreq_o), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_stall", 32'(stallreq_o), 32'd0);
    rst = 1'b0; aluop_i = OP_NOP;
    @(negedge clk);
    chk("post_rst_stall", 32'(stallreq_o), 32'd0);
    run_div("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 32'd0);

    step(OP_NOP, SEL_NOP, 32'h0, 32'h0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got still running want finished");
    $fatal(1, "timeout");
  end
endmodule
